mem_stage: RTL and testbench

Memory-access stage of the 32-bit pipelined CPU. It consumes the EX/MEM pipeline register outputs (ex_*), performs word loads and stores over the shared bus through a request/grant/ready handshake, and detects misaligned accesses. It then registers the MEM/WB pipeline outputs (mem_*). While a bus access is outstanding it raises `busy` to the pipeline controller, which folds it into the global `stall`.

---
 rtl/mem_stage.sv | 170 +++++++++++++++++
 tb/tb_mem_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: word load/store over the shared request/grant/ready bus,
// misalignment detection and the MEM/WB pipeline register.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    output logic        busy,
    input  logic [29:0] ex_pc,
    input  logic        ex_en,
    input  logic        ex_br_flag,
    input  logic [1:0]  ex_mem_op,
    input  logic [31:0] ex_mem_wr_data,
    input  logic [1:0]  ex_ctrl_op,
    input  logic [4:0]  ex_dst_addr,
    input  logic        ex_gpr_we_,
    input  logic [2:0]  ex_exp_code,
    input  logic [31:0] ex_out,
    output logic        bus_req_,
    input  logic        bus_grnt_,
    output logic        bus_as_,
    output logic        bus_rw,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wr_data,
    input  logic [31:0] bus_rd_data,
    input  logic        bus_rdy_,
    output logic [29:0] mem_pc,
    output logic        mem_en,
    output logic        mem_br_flag,
    output logic [1:0]  mem_ctrl_op,
    output logic [4:0]  mem_dst_addr,
    output logic        mem_gpr_we_,
    output logic [2:0]  mem_exp_code,
    output logic [31:0] mem_out
);

    localparam logic [1:0] MEM_OP_NOP  = 2'b00;
    localparam logic [1:0] MEM_OP_LDW  = 2'b01;
    localparam logic [1:0] CTRL_OP_NOP = 2'b00;
    localparam logic [2:0] EXP_NO_EXP  = 3'b000;
    localparam logic [2:0] EXP_MISS_AL = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_REQ    = 2'b01,
        ST_ACCESS = 2'b10,
        ST_STALL  = 2'b11
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_rd_buf;
    logic        w_rd_buf_we;
    logic        w_mem_valid;
    logic        w_acc_req;
    logic        w_miss_align;
    logic [31:0] w_ld_data;

    assign w_mem_valid  = ex_en && (ex_mem_op != MEM_OP_NOP) && (ex_exp_code == EXP_NO_EXP);
    assign w_acc_req    = w_mem_valid && (ex_out[1:0] == 2'b00) && !flush;
    assign w_miss_align = w_mem_valid && (ex_out[1:0] != 2'b00);

    assign bus_addr    = ex_out[31:2];
    assign bus_wr_data = ex_mem_wr_data;
    assign bus_rw      = (ex_mem_op == MEM_OP_LDW);

    // Once the pipeline is stalled externally after ready, the bus value is gone.
    assign w_ld_data = (r_state == ST_STALL) ? r_rd_buf : bus_rd_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_rd_buf <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_rd_buf_we) begin
                r_rd_buf <= bus_rd_data;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        bus_req_    = 1'b1;
        bus_as_     = 1'b1;
        busy        = 1'b0;
        w_rd_buf_we = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_acc_req) begin
                    bus_req_ = 1'b0;
                    busy     = 1'b1;
                    w_next   = ST_REQ;
                end
            end
            ST_REQ: begin
                bus_req_ = 1'b0;
                busy     = 1'b1;
                if (!bus_grnt_) begin
                    bus_as_ = 1'b0;
                    w_next  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                bus_req_ = 1'b0;
                if (bus_rdy_) begin
                    busy = 1'b1;
                end else begin
                    w_rd_buf_we = 1'b1;
                    w_next      = stall ? ST_STALL : ST_IDLE;
                end
            end
            ST_STALL: begin
                if (!stall) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        // Strobes drop the moment reset rises, not at the next edge.
        if (reset) begin
            bus_req_ = 1'b1;
            bus_as_  = 1'b1;
            busy     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_pc       <= 30'h0;
            mem_en       <= 1'b0;
            mem_br_flag  <= 1'b0;
            mem_ctrl_op  <= CTRL_OP_NOP;
            mem_dst_addr <= 5'h0;
            mem_gpr_we_  <= 1'b1;
            mem_exp_code <= EXP_NO_EXP;
            mem_out      <= 32'h0;
        end else if (!stall) begin
            if (flush) begin
                mem_pc       <= 30'h0;
                mem_en       <= 1'b0;
                mem_br_flag  <= 1'b0;
                mem_ctrl_op  <= CTRL_OP_NOP;
                mem_dst_addr <= 5'h0;
                mem_gpr_we_  <= 1'b1;
                mem_exp_code <= EXP_NO_EXP;
                mem_out      <= 32'h0;
            end else if (w_miss_align) begin
                mem_pc       <= ex_pc;
                mem_en       <= ex_en;
                mem_br_flag  <= ex_br_flag;
                mem_ctrl_op  <= CTRL_OP_NOP;
                mem_dst_addr <= 5'h0;
                mem_gpr_we_  <= 1'b1;
                mem_exp_code <= EXP_MISS_AL;
                mem_out      <= 32'h0;
            end else begin
                mem_pc       <= ex_pc;
                mem_en       <= ex_en;
                mem_br_flag  <= ex_br_flag;
                mem_ctrl_op  <= ex_ctrl_op;
                mem_dst_addr <= ex_dst_addr;
                mem_gpr_we_  <= ex_gpr_we_;
                mem_exp_code <= ex_exp_code;
                mem_out      <= (ex_mem_op == MEM_OP_LDW) ? w_ld_data : ex_out;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed and random instructions, a wait-state bus
// responder, and a scoreboard that checks every MEM/WB capture.
module tb_mem_stage;

    logic        clk, reset, stall, flush, busy, ext_stall;
    logic [29:0] ex_pc;
    logic        ex_en, ex_br_flag, ex_gpr_we_;
    logic [1:0]  ex_mem_op, ex_ctrl_op;
    logic [31:0] ex_mem_wr_data, ex_out;
    logic [4:0]  ex_dst_addr;
    logic [2:0]  ex_exp_code;
    logic        bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data, bus_rd_data;
    logic [29:0] mem_pc;
    logic        mem_en, mem_br_flag, mem_gpr_we_;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;

    assign stall = busy | ext_stall;

    mem_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
        .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
        .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
        .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
        .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_as_(bus_as_), .bus_rw(bus_rw),
        .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
        .bus_rdy_(bus_rdy_), .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag),
        .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_),
        .mem_exp_code(mem_exp_code), .mem_out(mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] pc;
        logic        en, br, we_;
        logic [1:0]  mop, cop;
        logic [31:0] wd, out, rd;
        logic [4:0]  dst;
        logic [2:0]  exc;
        int          gw, rw, sc, fc;
    } instr_t;

    typedef struct {
        logic [29:0] pc;
        logic        en, br, we_;
        logic [1:0]  cop;
        logic [4:0]  dst;
        logic [2:0]  exc;
        logic [31:0] out;
    } wb_t;

    wb_t         sb_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          in_instr = 0;
    int          cur_gw = 0, cur_rw = 0;
    logic [31:0] cur_rd = 0, cur_wd = 0;
    logic [29:0] cur_addr = 0;
    logic        cur_rw_bit = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic wb_t wb_reset();
        wb_t w;
        w.pc = 0; w.en = 0; w.br = 0; w.cop = 0; w.dst = 0; w.we_ = 1; w.exc = 0; w.out = 0;
        return w;
    endfunction

    function automatic bit uses_bus(instr_t t);
        return t.en && t.mop != 2'd0 && t.exc == 3'd0 && t.out[1:0] == 2'd0 && t.fc != 0;
    endfunction

    // Reference: what the MEM/WB register must hold once the instruction retires.
    function automatic wb_t model(instr_t t);
        wb_t w;
        bit  memop;
        memop = t.en && t.mop != 2'd0 && t.exc == 3'd0;
        if (t.fc == 0) return wb_reset();
        w.pc = t.pc; w.en = t.en; w.br = t.br;
        if (memop && t.out[1:0] != 2'd0) begin
            w.cop = 0; w.dst = 0; w.we_ = 1; w.exc = 3'd4; w.out = 0;
        end else begin
            w.cop = t.cop; w.dst = t.dst; w.we_ = t.we_; w.exc = t.exc;
            w.out = (t.mop == 2'd1) ? t.rd : t.out;
        end
        return w;
    endfunction

    function automatic instr_t blank();
        instr_t t;
        t.pc = 0; t.en = 1; t.br = 0; t.we_ = 1; t.mop = 0; t.cop = 0; t.wd = 0;
        t.out = 0; t.rd = 0; t.dst = 0; t.exc = 0; t.gw = 0; t.rw = 0; t.sc = 0; t.fc = -1;
        return t;
    endfunction

    task automatic apply(input instr_t t);
        ex_pc = t.pc; ex_en = t.en; ex_br_flag = t.br; ex_mem_op = t.mop;
        ex_mem_wr_data = t.wd; ex_ctrl_op = t.cop; ex_dst_addr = t.dst;
        ex_gpr_we_ = t.we_; ex_exp_code = t.exc; ex_out = t.out;
        cur_gw = t.gw; cur_rw = t.rw; cur_rd = t.rd; cur_wd = t.wd;
        cur_addr = t.out[31:2]; cur_rw_bit = (t.mop == 2'd1);
    endtask

    // Called at posedge+1; returns at posedge+1 just after the capture edge.
    task automatic issue(input instr_t t);
        int c, nb;
        bit done, sawreq, used;
        used = uses_bus(t);
        apply(t);
        sb_q.push_back(model(t));
        in_instr = 1;
        c = 0; nb = 0; done = 0; sawreq = 0;
        while (!done && c < 60) begin
            ext_stall = (c < t.sc);
            flush     = (c == t.fc);
            @(negedge clk); #3;
            if (busy) nb++;
            if (!bus_req_) sawreq = 1;
            if (!stall) done = 1;
            @(posedge clk); #1;
            c++;
        end
        ext_stall = 0; flush = 0; in_instr = 0;
        if (!done) chk("retire_timeout", 32'(c), 32'(0));
        chk("busy_cycles", 32'(nb), used ? 32'(t.gw + 2 + t.rw) : 32'(0));
        chk("bus_requested", 32'(sawreq), 32'(used));
    endtask

    // Bus slave: grant after cur_gw extra REQ cycles, ready after cur_rw waits.
    initial begin
        int k, j;
        bit ph;
        k = 0; j = 0; ph = 0;
        bus_grnt_ = 1; bus_rdy_ = 1; bus_rd_data = 0;
        forever begin
            @(negedge clk);
            bus_grnt_ = 1; bus_rdy_ = 1; bus_rd_data = $urandom;
            if (reset) begin
                ph = 0; k = 0; j = 0;
            end else if (!ph) begin
                if (!bus_req_) begin
                    if (k >= 1 + cur_gw) begin
                        bus_grnt_ = 0;
                        #1;
                        chk("bus_as_", 32'(bus_as_), 32'(0));
                        chk("bus_addr", 32'(bus_addr), 32'(cur_addr));
                        chk("bus_rw", 32'(bus_rw), 32'(cur_rw_bit));
                        chk("bus_wr_data", bus_wr_data, cur_wd);
                        ph = 1; j = 0; k = 0;
                    end else begin
                        k++;
                    end
                end else begin
                    k = 0;
                end
            end else begin
                if (j >= cur_rw) begin
                    bus_rdy_ = 0; bus_rd_data = cur_rd; ph = 0;
                end else begin
                    j++;
                end
            end
        end
    end

    // Scoreboard monitor: a cycle with stall low inside an instruction is a capture.
    initial begin
        bit  pend;
        wb_t e;
        pend = 0;
        forever begin
            @(negedge clk);
            if (pend && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("mem_pc", 32'(mem_pc), 32'(e.pc));
                chk("mem_en", 32'(mem_en), 32'(e.en));
                chk("mem_br_flag", 32'(mem_br_flag), 32'(e.br));
                chk("mem_ctrl_op", 32'(mem_ctrl_op), 32'(e.cop));
                chk("mem_dst_addr", 32'(mem_dst_addr), 32'(e.dst));
                chk("mem_gpr_we_", 32'(mem_gpr_we_), 32'(e.we_));
                chk("mem_exp_code", 32'(mem_exp_code), 32'(e.exc));
                chk("mem_out", mem_out, e.out);
            end
            #2;
            pend = in_instr && !stall && !reset;
        end
    end

    task automatic chk_wb_reset(input string tag);
        chk({tag, "_mem_pc"}, 32'(mem_pc), 32'(0));
        chk({tag, "_mem_en"}, 32'(mem_en), 32'(0));
        chk({tag, "_mem_dst"}, 32'(mem_dst_addr), 32'(0));
        chk({tag, "_mem_we_"}, 32'(mem_gpr_we_), 32'(1));
        chk({tag, "_mem_exp"}, 32'(mem_exp_code), 32'(0));
        chk({tag, "_mem_out"}, mem_out, 32'h0);
        chk({tag, "_bus_req_"}, 32'(bus_req_), 32'(1));
        chk({tag, "_bus_as_"}, 32'(bus_as_), 32'(1));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t t;
        bit     used;
        reset = 1; ext_stall = 0; flush = 0;
        apply(blank());
        repeat (3) @(negedge clk);
        #3;
        chk_wb_reset("por");
        reset = 0;
        @(posedge clk); #1;

        t = blank(); t.pc = 30'h11; t.out = 32'h1234_5678; t.dst = 5'd3; t.we_ = 0; t.cop = 2'd1;
        issue(t);

        // Reset while ACCESS waits for ready.
        t = blank(); t.mop = 2'd1; t.out = 32'h200; t.rw = 8; t.rd = 32'h5555_AAAA;
        apply(t);
        repeat (3) begin @(negedge clk); @(posedge clk); #1; end
        @(negedge clk); #3;
        chk("busy_before_reset", 32'(busy), 32'(1));
        reset = 1;
        #1;
        chk_wb_reset("midrst");
        t = blank(); t.en = 0;
        apply(t);
        @(posedge clk); @(negedge clk); #3;
        reset = 0;
        #1;
        chk("post_rst_bus_req_", 32'(bus_req_), 32'(1));
        chk("post_rst_busy", 32'(busy), 32'(0));
        @(posedge clk); #1;

        t = blank(); t.mop = 2'd1; t.out = 32'h0000_0040; t.rd = 32'h0BAD_F00D; t.dst = 5'd7; t.we_ = 0;
        issue(t);
        t = blank(); t.mop = 2'd1; t.out = 32'h0000_0100; t.gw = 1; t.rw = 1; t.rd = 32'hDEAD_BEEF;
        t.dst = 5'd9; t.we_ = 0; t.pc = 30'h40;
        issue(t);
        t = blank(); t.mop = 2'd2; t.out = 32'h0000_0102; t.wd = 32'h7777_1111; t.dst = 5'd4; t.pc = 30'h41;
        issue(t);
        t = blank(); t.mop = 2'd1; t.out = 32'h0000_0F00; t.rd = 32'hCAFE_F00D; t.sc = 5; t.we_ = 0;
        t.dst = 5'd12; t.pc = 30'h42;
        issue(t);
        t = blank(); t.mop = 2'd2; t.out = 32'h0000_0300; t.wd = 32'h1357_9BDF; t.fc = 0; t.pc = 30'h43;
        issue(t);
        t = blank(); t.mop = 2'd1; t.out = 32'h0000_0304; t.gw = 1; t.rw = 2; t.fc = 1;
        t.rd = 32'h2468_ACE0; t.dst = 5'd5; t.we_ = 0; t.pc = 30'h44;
        issue(t);

        for (int n = 0; n < 60; n++) begin
            t = blank();
            t.pc = 30'($urandom); t.en = ($urandom_range(0, 7) != 0); t.br = 1'($urandom);
            t.mop = 2'($urandom_range(0, 2)); t.wd = $urandom; t.cop = 2'($urandom);
            t.dst = 5'($urandom); t.we_ = 1'($urandom); t.out = $urandom; t.rd = $urandom;
            t.exc = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 4)) : 3'd0;
            if ($urandom_range(0, 1) == 1) t.out[1:0] = 2'b00;
            if (t.mop == 2'd1) begin t.en = 1; t.exc = 0; end
            t.gw = $urandom_range(0, 3); t.rw = $urandom_range(0, 3);
            t.sc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : 0;
            used = uses_bus(t);
            case ($urandom_range(0, 9))
                0: begin t.fc = 0; t.sc = 0; end
                1: if (used) t.fc = 1;
                default: ;
            endcase
            issue(t);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
